// File: rtl/logic_gate_pkg.sv
// Shared opcode definitions for the registered bitwise gate pipeline.
package logic_gate_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  // Codes above XNOR carry no function and produce a zero result.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op > OP_XNOR;
  endfunction

endpackage

// File: rtl/logic_gate_alu.sv
// Combinational bitwise function unit: y = f(op)(a, b), zero for illegal ops.
module logic_gate_alu
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function; anything unlisted yields zero.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered bitwise gate stage with valid/ready handshake, 2-entry skid
// buffering, a saturating completion counter and a sticky illegal-op flag.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [OP_W-1:0]  op_out,
  output logic             err_illegal,
  output logic [CNT_W-1:0] cnt_done
);

  logic [WIDTH-1:0] alu_y;
  logic             accept;
  logic             drain;

  logic             main_valid;
  logic [WIDTH-1:0] main_y;
  logic [OP_W-1:0]  main_op;

  logic             skid_full;
  logic [WIDTH-1:0] skid_y;
  logic [OP_W-1:0]  skid_op;

  logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (alu_y)
  );

  // in_ready depends only on registered skid occupancy, never on out_ready.
  assign in_ready  = !skid_full;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;

  assign out_valid = main_valid;
  assign y         = main_y;
  assign op_out    = main_op;

  // Main/skid storage: skid refills main first on drain, keeping FIFO order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_y     <= '0;
      main_op    <= '0;
      skid_full  <= 1'b0;
      skid_y     <= '0;
      skid_op    <= '0;
    end else begin
      if (drain) begin
        // accept cannot coincide with a full skid, so no new data is lost here.
        if (skid_full) begin
          main_y    <= skid_y;
          main_op   <= skid_op;
          skid_full <= 1'b0;
        end else if (accept) begin
          main_y  <= alu_y;
          main_op <= op;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (main_valid) begin
          skid_y    <= alu_y;
          skid_op   <= op;
          skid_full <= 1'b1;
        end else begin
          main_y     <= alu_y;
          main_op    <= op;
          main_valid <= 1'b1;
        end
      end
    end
  end

  // Sticky flag for any accepted illegal opcode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else if (accept && is_illegal_op(op)) begin
      err_illegal <= 1'b1;
    end
  end

  // Saturating count of output handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_done <= '0;
    end else if (drain && (cnt_done != '1)) begin
      cnt_done <= cnt_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: truth-table vectors, hand-written
// backpressure/illegal/reset/saturation sequences, and randomized traffic
// scored against a queue-based 2-deep FIFO reference model.
module tb_logic_gate_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [2:0] op_out;
  logic       err_illegal;
  logic [15:0] cnt_done;

  logic       in_ready_s;
  logic       out_valid_s;
  logic [7:0] y_s;
  logic [2:0] op_out_s;
  logic       err_s;
  logic [2:0] cnt_s;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .op_out(op_out), .err_illegal(err_illegal), .cnt_done(cnt_done)
  );

  logic_gate_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .y(y_s), .op_out(op_out_s), .err_illegal(err_s), .cnt_done(cnt_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] y;
  } res_t;

  res_t q[$];
  int   acc_cnt = 0;
  int   hs      = 0;
  bit   m_err   = 1'b0;
  bit   chk_en  = 1'b0;
  bit   m_acc, m_drn;

  function automatic logic [7:0] gate_ref(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (o)
        3'd0: r[i] = x[i] && z[i];
        3'd1: r[i] = x[i] || z[i];
        3'd2: r[i] = !(x[i] && z[i]);
        3'd3: r[i] = !(x[i] || z[i]);
        3'd4: r[i] = x[i] != z[i];
        3'd5: r[i] = x[i] == z[i];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Model: a FIFO holding at most two results, updated on every clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
      hs    = 0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_drn = out_ready && (q.size() > 0);
      if (m_drn) begin
        void'(q.pop_front());
        hs++;
      end
      if (m_acc) begin
        q.push_back('{op: op, y: gate_ref(op, a, b)});
        acc_cnt++;
        if (op > 3'd5) m_err = 1'b1;
      end
    end
  end

  // Continuous scoreboard comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("err_illegal", err_illegal, m_err);
      chk("cnt_done", cnt_done, (hs > 65535) ? 65535 : hs);
      chk("cnt_sat", cnt_s, (hs > 7) ? 7 : hs);
      chk("out_valid_s", out_valid_s, q.size() > 0);
      chk("in_ready_s", in_ready_s, q.size() < 2);
      chk("err_s", err_s, m_err);
      if (q.size() > 0) begin
        chk("y", y, q[0].y);
        chk("op_out", op_out, q[0].op);
        chk("y_s", y_s, q[0].y);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
    int start;
    bit got;
    start    = acc_cnt;
    got      = 1'b0;
    in_valid = 1'b1;
    op = o; a = aa; b = bb;
    for (int n = 0; n < 50 && !got; n++) begin
      @(posedge clk); #1;
      if (acc_cnt != start) got = 1'b1;
    end
    if (!got) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int base_acc, base_hs, n;
    tbl[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0};
    tbl[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC};
    tbl[2] = '{3'd2, 8'hF0, 8'hCC, 8'h3F};
    tbl[3] = '{3'd3, 8'hF0, 8'hCC, 8'h03};
    tbl[4] = '{3'd4, 8'hF0, 8'hCC, 8'h3C};
    tbl[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_cnt", cnt_done, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Truth table, back-to-back with one cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
      @(posedge clk); #1;
      chk("tt_valid", out_valid, 1);
      chk("tt_y", y, tbl[i].y);
      chk("tt_op", op_out, tbl[i].op);
    end
    in_valid = 1'b0;
    wait_empty();

    // Backpressure: two accepted, third held until the consumer drains.
    out_ready = 1'b0;
    base_acc  = acc_cnt;
    base_hs   = hs;
    in_valid  = 1'b1; op = 3'd4; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    chk("bp_ready1", in_ready, 1);
    op = 3'd0; a = 8'hAA; b = 8'h0F;
    @(posedge clk); #1;
    chk("bp_ready2", in_ready, 0);
    chk("bp_y_head", y, 8'h33);
    op = 3'd3; a = 8'h01; b = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held_ready", in_ready, 0);
    chk("bp_held_y", y, 8'h33);
    chk("bp_acc2", acc_cnt - base_acc, 2);
    out_ready = 1'b1;
    n = 0;
    while (acc_cnt - base_acc < 3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_acc3", acc_cnt - base_acc, 3);
    in_valid = 1'b0;
    wait_empty();
    chk("bp_drained", hs - base_hs, 3);

    // Illegal op flows with zero result and sets the sticky flag.
    send(3'd7, 8'hFF, 8'hFF);
    chk("ill_y", y, 0);
    chk("ill_op", op_out, 7);
    chk("ill_err", err_illegal, 1);
    send(3'd1, 8'h0F, 8'h30);
    chk("ill_sticky_y", y, 8'h3F);
    chk("ill_sticky_err", err_illegal, 1);
    wait_empty();

    // Reset mid-traffic with both buffers full and the error flag set.
    out_ready = 1'b0;
    in_valid  = 1'b1; op = 3'd1; a = 8'h5A; b = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_op", op_out, 0);
    chk("mid_rst_cnt", cnt_done, 0);
    chk("mid_rst_err", err_illegal, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    // Counter saturation: ten handshakes on the 3-bit counter.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(3'(i % 6), 8'(i), 8'hC3);
    wait_empty();
    chk("sat_cnt3", cnt_s, 7);
    chk("sat_cnt16", cnt_done, 10);

    // Randomized traffic against the scoreboard.
    base_acc = acc_cnt;
    base_hs  = hs;
    n = 0;
    while (acc_cnt - base_acc < 100 && n < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      if (acc_cnt - base_acc == 100) in_valid = 1'b0;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rnd_accepted", acc_cnt - base_acc, 100);
    wait_empty();
    chk("rnd_delivered", hs - base_hs, 100);
    chk("rnd_cnt_sat", cnt_s, 7);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
